// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results queue in a
// small FIFO and a starvation counter forces a one-cycle stall to drain them.
module wb_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              stall_req,
    input  logic [ADDR_W-1:0] hz_addr,
    output logic              hz_match,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              proto_err
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } arbState_t;

    arbState_t stateReg, stateNext;

    logic [ADDR_W-1:0]   addrMem [FIFO_DEPTH];
    logic [DATA_W-1:0]   dataMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtrReg, rdPtrReg;
    logic [CNT_W-1:0]    countReg, countNext;
    logic [STARVE_W-1:0] starveReg, starveNext;
    logic                mduReadyReg;
    logic                stallReg;
    logic                protoErrReg;
    logic                rfWeReg;
    logic [ADDR_W-1:0]   rfWaddrReg;
    logic [DATA_W-1:0]   rfWdataReg;

    logic push;
    logic pipeValid;
    logic pipeGrant;
    logic popGrant;
    logic [FIFO_DEPTH-1:0] slotHit;

    // Results for r0 are acknowledged but never stored, so they never take a grant.
    assign push      = mdu_valid && mduReadyReg && (mdu_addr != '0);
    assign pipeValid = pipe_we && (pipe_addr != '0);

    always_comb begin
        stateNext  = stateReg;
        starveNext = starveReg;
        pipeGrant  = 1'b0;
        popGrant   = 1'b0;
        countNext  = countReg;

        case (stateReg)
            IDLE: begin
                pipeGrant  = pipeValid;
                starveNext = '0;
            end
            DRAIN: begin
                if (pipeValid) begin
                    pipeGrant = 1'b1;
                    if (starveReg != LIMIT_C) begin
                        starveNext = starveReg + STARVE_W'(1);
                    end
                end else begin
                    popGrant   = 1'b1;
                    starveNext = '0;
                end
            end
            FORCE: begin
                popGrant   = 1'b1;
                starveNext = '0;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (push && !popGrant) begin
            countNext = countReg + CNT_W'(1);
        end else if (!push && popGrant) begin
            countNext = countReg - CNT_W'(1);
        end

        case (stateReg)
            IDLE: begin
                if (push) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (starveNext == LIMIT_C) begin
                    stateNext = FORCE;
                end else if (countNext == '0) begin
                    stateNext = IDLE;
                end
            end
            FORCE: begin
                stateNext = (countNext == '0) ? IDLE : DRAIN;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gSlot
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(gi) - rdPtrReg;
        assign slotHit[gi] = (CNT_W'(offset) < countReg) && (addrMem[gi] == hz_addr);
    end

    assign hz_match = (hz_addr != '0) &&
                      ((|slotHit) || (mdu_valid && (mdu_addr == hz_addr)));

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addrMem[wrPtrReg] <= mdu_addr;
            dataMem[wrPtrReg] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            starveReg   <= '0;
            countReg    <= '0;
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            mduReadyReg <= 1'b1;
            stallReg    <= 1'b0;
            protoErrReg <= 1'b0;
            rfWeReg     <= 1'b0;
            rfWaddrReg  <= '0;
            rfWdataReg  <= '0;
        end else begin
            stateReg    <= stateNext;
            starveReg   <= starveNext;
            countReg    <= countNext;
            mduReadyReg <= (countNext != DEPTH_C);
            stallReg    <= (stateNext == FORCE);
            if (push) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (popGrant) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (stallReg && pipe_we) begin
                protoErrReg <= 1'b1;
            end
            rfWeReg <= pipeGrant || popGrant;
            if (popGrant) begin
                rfWaddrReg <= addrMem[rdPtrReg];
                rfWdataReg <= dataMem[rdPtrReg];
            end else if (pipeGrant) begin
                rfWaddrReg <= pipe_addr;
                rfWdataReg <= pipe_data;
            end
        end
    end

    assign mdu_ready = mduReadyReg;
    assign stall_req = stallReg;
    assign proto_err = protoErrReg;
    assign rf_we     = rfWeReg;
    assign rf_waddr  = rfWaddrReg;
    assign rf_wdata  = rfWdataReg;

endmodule
